// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit (master) and imem (slave).
interface if_fetch_unit_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int INST_WIDTH = 16
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ack;
    logic [INST_WIDTH-1:0] data;

    modport master (output req, addr, input ack, data);
    modport slave  (input req, addr, output ack, data);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, registered output to decode
// with a single-entry skid buffer, flush kill and a sticky wait-timeout flag.
module if_fetch_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int INST_WIDTH = 16,
    parameter int TIMEOUT    = 15,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  flush_i,
    input  logic [5:0]            stall_i,
    if_fetch_unit_if.master       imem,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic                  inst_valid_o,
    output logic                  stallreq_o,
    output logic                  err_o
);
    typedef enum logic [1:0] {IDLE, WAIT, DROP, HOLD} state_t;

    localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT);

    state_t                state, state_nxt;
    logic                  free, fetch_done, waiting;
    logic                  issue, retire, load_mem, load_skid, skid_wr;
    logic [INST_WIDTH-1:0] skid_data;
    logic [ADDR_WIDTH-1:0] skid_addr;
    logic [CNT_WIDTH-1:0]  cnt, cnt_inc;
    logic                  unused_stall;

    assign unused_stall = ^{stall_i[5], stall_i[3:0]};

    assign free       = !inst_valid_o || !stall_i[4];
    assign fetch_done = (state == WAIT) && imem.ack && !flush_i;
    // Dropped during flush so the redirect target can load into the PC.
    assign stallreq_o = !fetch_done && !flush_i;
    assign waiting    = ((state == WAIT) || (state == DROP)) && !imem.ack;
    assign cnt_inc    = (cnt == TMO) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        retire    = 1'b0;
        load_mem  = 1'b0;
        load_skid = 1'b0;
        skid_wr   = 1'b0;
        case (state)
            IDLE: if (!flush_i) begin
                issue     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (imem.ack) begin
                    retire = 1'b1;
                    if (flush_i) state_nxt = IDLE;
                    else if (free) begin
                        load_mem  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        skid_wr   = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (flush_i) begin
                    state_nxt = DROP;
                end
            end
            // Request already on the bus must still complete; its data is thrown away.
            DROP: if (imem.ack) begin
                retire    = 1'b1;
                state_nxt = IDLE;
            end
            HOLD: begin
                if (flush_i) state_nxt = IDLE;
                else if (free) begin
                    load_skid = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            imem.req     <= 1'b0;
            imem.addr    <= '0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
            skid_data    <= '0;
            skid_addr    <= '0;
            cnt          <= '0;
            err_o        <= 1'b0;
        end else begin
            if (issue) begin
                imem.req  <= 1'b1;
                imem.addr <= pc_i;
            end else if (retire) begin
                imem.req  <= 1'b0;
            end

            if (skid_wr) begin
                skid_data <= imem.data;
                skid_addr <= imem.addr;
            end

            if (flush_i) begin
                inst_valid_o <= 1'b0;
            end else if (load_mem) begin
                inst_o       <= imem.data;
                inst_pc_o    <= imem.addr;
                inst_valid_o <= 1'b1;
            end else if (load_skid) begin
                inst_o       <= skid_data;
                inst_pc_o    <= skid_addr;
                inst_valid_o <= 1'b1;
            end else if (free) begin
                inst_valid_o <= 1'b0;
            end

            // Timeout only flags; the request stays up until memory answers.
            cnt <= waiting ? cnt_inc : '0;
            if (waiting && cnt_inc == TMO) err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboarded bench for if_fetch_unit: a decode-side monitor pops expected (inst, pc)
// pairs whenever decode takes an instruction; scenario tasks drive imem and check inline.
module tb_if_fetch_unit;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc = '0;
    logic        flush = 1'b0;
    logic [5:0]  stall = '0;
    logic [15:0] inst, inst_pc;
    logic        inst_valid, stallreq, err;

    int   checks = 0;
    int   errors = 0;
    bit   err_sticky = 1'b0;
    exp_t exp_q[$];

    if_fetch_unit_if #(.ADDR_WIDTH(16), .INST_WIDTH(16)) imem_bus ();

    if_fetch_unit #(.ADDR_WIDTH(16), .INST_WIDTH(16), .TIMEOUT(TIMEOUT), .CNT_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .flush_i(flush), .stall_i(stall),
        .imem(imem_bus), .inst_o(inst), .inst_pc_o(inst_pc), .inst_valid_o(inst_valid),
        .stallreq_o(stallreq), .err_o(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Decode consumes the output whenever it is valid and bit 4 of stall is low.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && inst_valid && !stall[4]) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL deliver: got inst=%h pc=%h, required no delivery", inst, inst_pc);
            end else begin
                e = exp_q.pop_front();
                if ({inst, inst_pc} !== {e.inst, e.pc}) begin
                    errors++;
                    $display("FAIL deliver: got inst=%h pc=%h, required inst=%h pc=%h",
                             inst, inst_pc, e.inst, e.pc);
                end
            end
        end
    end

    // Wait for the request to pc, hold ack off for delay cycles, then ack with d.
    // Memory-side inputs change at negedge; returns just after the ack edge.
    task automatic do_fetch(input logic [15:0] a, input int delay, input logic [15:0] d,
                            input bit push, input bit flush_ack, output int issue_cyc);
        int n = 0;
        pc = a;
        imem_bus.ack = 1'b0;
        @(negedge clk);
        while (!imem_bus.req && n < 8) begin
            @(negedge clk);
            n++;
        end
        issue_cyc = n;
        checks++;
        if (imem_bus.req !== 1'b1 || imem_bus.addr !== a) begin
            errors++;
            $display("FAIL issue: req=%b addr=%h, required req=1 addr=%h", imem_bus.req, imem_bus.addr, a);
        end
        for (int i = 0; i < delay; i++) begin
            if (i >= TIMEOUT) err_sticky = 1'b1;
            checks++;
            if ({imem_bus.req, imem_bus.addr, stallreq, err} !== {1'b1, a, 1'b1, err_sticky}) begin
                errors++;
                $display("FAIL wait[%0d]: req=%b addr=%h stallreq=%b err=%b, required 1 %h 1 %b",
                         i, imem_bus.req, imem_bus.addr, stallreq, err, a, err_sticky);
            end
            @(negedge clk);
        end
        if (delay >= TIMEOUT) err_sticky = 1'b1;
        imem_bus.ack  = 1'b1;
        imem_bus.data = d;
        if (flush_ack) flush = 1'b1;
        if (push && !flush_ack) exp_q.push_back('{inst: d, pc: a});
        #1;
        checks++;
        if ({imem_bus.req, imem_bus.addr, stallreq, err} !== {1'b1, a, 1'b0, err_sticky}) begin
            errors++;
            $display("FAIL ack_cycle: req=%b addr=%h stallreq=%b err=%b, required 1 %h 0 %b",
                     imem_bus.req, imem_bus.addr, stallreq, err, a, err_sticky);
        end
        @(posedge clk);
        #1;
        imem_bus.ack = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        imem_bus.ack = 1'b0;
        imem_bus.data = 16'hFFFF;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({imem_bus.req, imem_bus.addr, inst, inst_pc, inst_valid, err} !== {1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: req=%b addr=%h inst=%h pc=%h valid=%b err=%b, required all 0",
                     imem_bus.req, imem_bus.addr, inst, inst_pc, inst_valid, err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        do_fetch(16'h0000, 1, 16'hA5A5, 1'b1, 1'b0, n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL first_issue: req after %0d cycles, required 1", n);
        end
        @(negedge clk);
        checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 16'hA5A5, 16'h0000}) begin
            errors++;
            $display("FAIL basic_out: valid=%b inst=%h pc=%h, required 1 a5a5 0000", inst_valid, inst, inst_pc);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_fetch(16'h0002, 0, 16'h0202, 1'b1, 1'b0, n);
        do_fetch(16'h0004, 0, 16'h0404, 1'b1, 1'b0, n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL issue_spacing: next req after %0d cycles, required 1", n);
        end
    endtask

    task automatic test_latency();
        int n;
        stall = 6'b101111;
        do_fetch(16'h0010, 3, 16'h5A5A, 1'b1, 1'b0, n);
    endtask

    task automatic test_hold();
        int n;
        stall = 6'b010000;
        do_fetch(16'h0020, 1, 16'h1234, 1'b1, 1'b0, n);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({inst_valid, inst, inst_pc, imem_bus.req} !== {1'b1, 16'h5A5A, 16'h0010, 1'b0}) begin
                errors++;
                $display("FAIL hold[%0d]: valid=%b inst=%h pc=%h req=%b, required 1 5a5a 0010 0",
                         i, inst_valid, inst, inst_pc, imem_bus.req);
            end
            @(posedge clk);
            #1;
        end
        stall = 6'b000000;
        pc = 16'h0030;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({inst_valid, inst, inst_pc, imem_bus.req} !== {1'b1, 16'h1234, 16'h0020, 1'b0}) begin
            errors++;
            $display("FAIL skid_release: valid=%b inst=%h pc=%h req=%b, required 1 1234 0020 0",
                     inst_valid, inst, inst_pc, imem_bus.req);
        end
    endtask

    task automatic test_flush_wait();
        int n = 0;
        pc = 16'h0030;
        @(negedge clk);
        while (!imem_bus.req && n < 8) begin
            @(negedge clk);
            n++;
        end
        flush = 1'b1;
        pc = 16'h0040;
        #1;
        checks++;
        if ({imem_bus.req, imem_bus.addr, stallreq} !== {1'b1, 16'h0030, 1'b0}) begin
            errors++;
            $display("FAIL flush_wait: req=%b addr=%h stallreq=%b, required 1 0030 0",
                     imem_bus.req, imem_bus.addr, stallreq);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 1) begin
                imem_bus.ack = 1'b1;
                imem_bus.data = 16'hDEAD;
                #1;
            end
            checks++;
            if ({imem_bus.req, imem_bus.addr, stallreq} !== {1'b1, 16'h0030, 1'b1}) begin
                errors++;
                $display("FAIL drop[%0d]: req=%b addr=%h stallreq=%b, required 1 0030 1",
                         i, imem_bus.req, imem_bus.addr, stallreq);
            end
        end
        @(posedge clk);
        #1;
        imem_bus.ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({inst_valid, imem_bus.req} !== 2'b00) begin
            errors++;
            $display("FAIL drop_done: valid=%b req=%b, required 0 0", inst_valid, imem_bus.req);
        end
        do_fetch(16'h0040, 1, 16'h4040, 1'b1, 1'b0, n);
    endtask

    task automatic test_flush_ack();
        int n;
        do_fetch(16'h0050, 1, 16'hBEEF, 1'b0, 1'b1, n);
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_ack: valid=%b, required 0", inst_valid);
        end
    endtask

    task automatic test_flush_hold();
        int n;
        do_fetch(16'h0060, 0, 16'h6060, 1'b0, 1'b0, n);
        stall = 6'b010000;
        do_fetch(16'h0070, 1, 16'hCAFE, 1'b0, 1'b0, n);
        pc = 16'h0080;
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if ({inst_valid, inst, imem_bus.req, stallreq} !== {1'b1, 16'h6060, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL flush_hold: valid=%b inst=%h req=%b stallreq=%b, required 1 6060 0 0",
                     inst_valid, inst, imem_bus.req, stallreq);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        stall = 6'b000000;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || inst === 16'hCAFE) begin
            errors++;
            $display("FAIL flush_hold_out: valid=%b inst=%h, required valid 0 and inst not cafe",
                     inst_valid, inst);
        end
        do_fetch(16'h0080, 1, 16'h8080, 1'b1, 1'b0, n);
    endtask

    task automatic test_timeout();
        int n;
        do_fetch(16'h0090, 20, 16'h9999, 1'b1, 1'b0, n);
        @(negedge clk);
        checks++;
        if ({err, inst_valid, inst} !== {1'b1, 1'b1, 16'h9999}) begin
            errors++;
            $display("FAIL timeout_done: err=%b valid=%b inst=%h, required 1 1 9999", err, inst_valid, inst);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        pc = 16'h00A0;
        @(negedge clk);
        while (!imem_bus.req && n < 8) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        err_sticky = 1'b0;
        @(negedge clk);
        checks++;
        if ({imem_bus.req, imem_bus.addr, err, inst_valid} !== {1'b0, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: req=%b addr=%h err=%b valid=%b, required 0 0000 0 0",
                     imem_bus.req, imem_bus.addr, err, inst_valid);
        end
        do_fetch(16'h00B0, 1, 16'hB0B0, 1'b1, 1'b0, n);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_latency();
        test_hold();
        test_flush_wait();
        test_flush_ack();
        test_flush_hold();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected instructions never delivered, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
